// File: rtl/rv_level_fifo_pkg.sv
// Shared width helpers and status bundle for rv_level_fifo.
// Optional high-water tracking is enabled with RV_FIFO_PEAK_EN.
package rv_fifo_pkg;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

endpackage

// File: rtl/rv_level_fifo_mem.sv
// DEPTH x DATA_W storage, one write port, one read port.
// Read data is registered and returns old contents on a same-address write.
module rv_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 10,
  parameter int ADDR_W = 4
) (
  input  logic              clock_port,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] ram [DEPTH];

  always_ff @(posedge clock_port) begin
    if (we) ram[waddr] <= wdata;
    rdata <= ram[raddr];
  end

endmodule

// File: rtl/rv_level_fifo.sv
// Parametrised ready/valid FIFO with flush, fill level and threshold flags.
// Define RV_FIFO_PEAK_EN to add the peak_level high-water output.
module rv_level_fifo
  import rv_fifo_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 10,
  parameter int AF_THRESHOLD = 8,
  parameter int AE_THRESHOLD = 2
) (
  input  logic                      clock_port,
  input  logic                      reset_port,
  input  logic [DATA_W-1:0]         input_port_data,
  input  logic                      input_port_valid,
  output logic                      input_port_ready,
  output logic [DATA_W-1:0]         output_port_data,
  output logic                      output_port_valid,
  input  logic                      output_port_ready,
  input  logic                      clear,
`ifdef RV_FIFO_PEAK_EN
  output logic [lvl_w(DEPTH)-1:0]   peak_level,
`endif
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic                      almost_full,
  output logic                      almost_empty
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int LVL_W  = lvl_w(DEPTH);

  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0]  AF_LVL = LVL_W'(AF_THRESHOLD);
  localparam logic [LVL_W-1:0]  AE_LVL = LVL_W'(AE_THRESHOLD);

  logic [ADDR_W-1:0] push_addr_q, push_addr_d;
  logic [ADDR_W-1:0] pop_addr_q, pop_addr_d;
  logic              looped_q, looped_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              fwd_sel_q, fwd_sel_d;
  logic [DATA_W-1:0] fwd_data_q;
  logic [DATA_W-1:0] mem_rdata;
  logic              push, pop;
  fifo_status_t      status;

  // clear discards any transfer offered in the same cycle
  assign push = input_port_valid & ~full_q & ~clear;
  assign pop  = output_port_ready & ~empty_q & ~clear;

  always_comb begin
    push_addr_d = push_addr_q;
    pop_addr_d  = pop_addr_q;
    looped_d    = looped_q;
    level_d     = level_q;
    if (clear) begin
      push_addr_d = '0;
      pop_addr_d  = '0;
      looped_d    = 1'b0;
      level_d     = '0;
    end else begin
      if (push) begin
        if (push_addr_q == LAST) begin
          push_addr_d = '0;
          looped_d    = ~looped_d;
        end else begin
          push_addr_d = push_addr_q + ADDR_W'(1);
        end
      end
      if (pop) begin
        if (pop_addr_q == LAST) begin
          pop_addr_d = '0;
          looped_d   = ~looped_d;
        end else begin
          pop_addr_d = pop_addr_q + ADDR_W'(1);
        end
      end
      unique case (1'b1)
        push & ~pop: level_d = level_q + LVL_W'(1);
        pop & ~push: level_d = level_q - LVL_W'(1);
        default:     level_d = level_q;
      endcase
    end
    empty_d   = (push_addr_d == pop_addr_d) & ~looped_d;
    full_d    = (push_addr_d == pop_addr_d) & looped_d;
    // head next cycle is the word being written now
    fwd_sel_d = push & (push_addr_q == pop_addr_d);
  end

  always_ff @(posedge clock_port or posedge reset_port) begin
    if (reset_port) begin
      push_addr_q <= '0;
      pop_addr_q  <= '0;
      looped_q    <= 1'b0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      level_q     <= '0;
      fwd_sel_q   <= 1'b0;
    end else begin
      push_addr_q <= push_addr_d;
      pop_addr_q  <= pop_addr_d;
      looped_q    <= looped_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      level_q     <= level_d;
      fwd_sel_q   <= fwd_sel_d;
    end
  end

  always_ff @(posedge clock_port) begin
    fwd_data_q <= input_port_data;
  end

  rv_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clock_port (clock_port),
    .we         (push),
    .waddr      (push_addr_q),
    .wdata      (input_port_data),
    .raddr      (pop_addr_d),
    .rdata      (mem_rdata)
  );

  assign status.empty        = empty_q;
  assign status.full         = full_q;
  assign status.almost_full  = (level_q >= AF_LVL);
  assign status.almost_empty = (level_q <= AE_LVL);

  assign input_port_ready  = ~status.full;
  assign output_port_valid = ~status.empty;
  assign output_port_data  = fwd_sel_q ? fwd_data_q : mem_rdata;
  assign level             = level_q;
  assign almost_full       = status.almost_full;
  assign almost_empty      = status.almost_empty;

`ifdef RV_FIFO_PEAK_EN
  logic [LVL_W-1:0] peak_q, peak_d;

  always_comb begin
    peak_d = peak_q;
    if (clear)                 peak_d = '0;
    else if (level_d > peak_q) peak_d = level_d;
  end

  always_ff @(posedge clock_port or posedge reset_port) begin
    if (reset_port) peak_q <= '0;
    else            peak_q <= peak_d;
  end

  assign peak_level = peak_q;
`endif

endmodule
